// File: rtl/gtxe2_chnl_rx_align_lock_pkg.sv
// Shared definitions for the GTXE2 RX comma aligner with lock tracking:
// alignment state and comma kind encodings, default comma values, offset width,
// and small arithmetic helpers used by the aligner datapath.
package gtxe2_chnl_rx_align_lock_pkg;

    localparam int OFF_W = 4;

    localparam logic [9:0] MCOMMA_DEF = 10'b1010000011;
    localparam logic [9:0] PCOMMA_DEF = 10'b0101111100;
    localparam logic [9:0] MASK_DEF   = 10'b1111111111;

    typedef enum logic {
        ST_UNALIGNED = 1'b0,
        ST_ALIGNED   = 1'b1
    } align_state_t;

    typedef enum logic {
        KIND_M = 1'b0,
        KIND_P = 1'b1
    } comma_kind_t;

    // Character-boundary offset of a window bit position.
    function automatic logic [OFF_W-1:0] mod10(input logic [7:0] k);
        return OFF_W'(k % 8'd10);
    endfunction

    // Next boundary offset for a manual slide, wrapping 9 -> 0.
    function automatic logic [OFF_W-1:0] off_next(input logic [OFF_W-1:0] off);
        return (off >= OFF_W'(9)) ? '0 : off + 1'b1;
    endfunction

    // Saturating 4-bit increment for the loss-of-lock counter.
    function automatic logic [3:0] sat_inc(input logic [3:0] c);
        return (c == 4'hF) ? c : c + 4'd1;
    endfunction

endpackage

// File: rtl/gtxe2_chnl_rx_align_lock_if.sv
// Bus between deserializer side and the comma aligner. RXSLIDE exists only
// when GTXE2_CHNL_RX_ALIGN_SLIDE_EN is defined.
interface gtxe2_chnl_rx_align_lock_if
    import gtxe2_chnl_rx_align_lock_pkg::*;
#(
    parameter int WIDTH = 20
);
    logic [WIDTH-1:0] indata;
    logic             rxelecidle;
    logic             RXCOMMADETEN;
    logic             RXPCOMMAALIGNEN;
    logic             RXMCOMMAALIGNEN;
`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
    logic             RXSLIDE;
`endif
    logic [WIDTH-1:0] outdata;
    logic             RXBYTEISALIGNED;
    logic             RXBYTEREALIGN;
    logic             RXCOMMADET;
    logic [OFF_W-1:0] comma_off;

    modport master (
        output indata, rxelecidle, RXCOMMADETEN, RXPCOMMAALIGNEN, RXMCOMMAALIGNEN,
`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
        output RXSLIDE,
`endif
        input  outdata, RXBYTEISALIGNED, RXBYTEREALIGN, RXCOMMADET, comma_off
    );

    modport slave (
        input  indata, rxelecidle, RXCOMMADETEN, RXPCOMMAALIGNEN, RXMCOMMAALIGNEN,
`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
        input  RXSLIDE,
`endif
        output outdata, RXBYTEISALIGNED, RXBYTEREALIGN, RXCOMMADET, comma_off
    );

endinterface

// File: rtl/gtxe2_chnl_rx_align_lock_cmp.sv
// Per-offset masked comma comparator over the 2-word window. Reports every
// matching start position, plus the lowest one and the kind of its first char.
module gtxe2_chnl_rx_align_lock_cmp
    import gtxe2_chnl_rx_align_lock_pkg::*;
#(
    parameter int         WIDTH  = 20,
    parameter logic [9:0] PVAL   = PCOMMA_DEF,
    parameter logic [9:0] MVAL   = MCOMMA_DEF,
    parameter logic [9:0] MASK   = MASK_DEF,
    parameter bit         PDET   = 1'b1,
    parameter bit         MDET   = 1'b1,
    parameter bit         DOUBLE = 1'b0,
    parameter int         KW     = $clog2(WIDTH)
) (
    input  logic [2*WIDTH-1:0] win_i,
    output logic [WIDTH-1:0]   hits_o,
    output logic               hit_o,
    output logic [KW-1:0]      k_o,
    output comma_kind_t        kind_o
);

    logic p_first;
    logic m_first;

    function automatic logic match10(input logic [9:0] s, input logic [9:0] v);
        return (s & MASK) == (v & MASK);
    endfunction

    // Scan from the top down so the lowest matching position is the one kept.
    always_comb begin
        hits_o  = '0;
        hit_o   = 1'b0;
        k_o     = '0;
        kind_o  = KIND_M;
        p_first = 1'b0;
        m_first = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (DOUBLE) begin
                p_first = PDET && match10(win_i[k +: 10], PVAL) && match10(win_i[k+10 +: 10], MVAL);
                m_first = MDET && match10(win_i[k +: 10], MVAL) && match10(win_i[k+10 +: 10], PVAL);
            end else begin
                p_first = PDET && match10(win_i[k +: 10], PVAL);
                m_first = MDET && match10(win_i[k +: 10], MVAL);
            end
            if (p_first || m_first) begin
                hits_o[k] = 1'b1;
                hit_o     = 1'b1;
                k_o       = KW'(k);
                kind_o    = p_first ? KIND_P : KIND_M;
            end
        end
    end

endmodule

// File: rtl/gtxe2_chnl_rx_align_lock.sv
// GTXE2 RX comma aligner with lock tracking. Holds the previous word to form
// the search window, the boundary offset, the UNALIGNED/ALIGNED state, the
// loss-of-lock counter and the status pulses. Optional manual slide is built
// in when GTXE2_CHNL_RX_ALIGN_SLIDE_EN is defined.
module gtxe2_chnl_rx_align_lock
    import gtxe2_chnl_rx_align_lock_pkg::*;
#(
    parameter int         WIDTH              = 20,
    parameter logic [9:0] ALIGN_MCOMMA_VALUE = MCOMMA_DEF,
    parameter logic [9:0] ALIGN_PCOMMA_VALUE = PCOMMA_DEF,
    parameter string      ALIGN_MCOMMA_DET   = "TRUE",
    parameter string      ALIGN_PCOMMA_DET   = "TRUE",
    parameter logic [9:0] ALIGN_COMMA_ENABLE = MASK_DEF,
    parameter string      ALIGN_COMMA_DOUBLE = "FALSE",
    parameter int         LOSS_COUNT         = 4
) (
    input logic clk,
    input logic rst,
    gtxe2_chnl_rx_align_lock_if.slave bus
);

    localparam bit         PDET     = (ALIGN_PCOMMA_DET == "TRUE");
    localparam bit         MDET     = (ALIGN_MCOMMA_DET == "TRUE");
    localparam bit         DOUBLE   = (ALIGN_COMMA_DOUBLE == "TRUE");
    localparam int         KW       = $clog2(WIDTH);
    localparam int         CW       = DOUBLE ? 20 : 10;
    localparam logic [3:0] LOSS_LIM = 4'(LOSS_COUNT);

    logic [WIDTH-1:0]   prev_q;
    logic [WIDTH-1:0]   outdata_q;
    logic [2*WIDTH-1:0] win;
    align_state_t       state_q, state_d;
    logic [OFF_W-1:0]   off_q, off_d;
    logic [3:0]         loss_q, loss_d;
    logic               realign_q, realign_d;
    logic               commadet_q, commadet_d;

    logic [WIDTH-1:0]   cmp_hits;
    logic               cmp_hit;
    logic [KW-1:0]      cmp_k;
    comma_kind_t        cmp_kind;
    logic [OFF_W-1:0]   koff;
    logic               comma_aligned;
    logic               realign_ok;
    logic               det_in_win;
    logic               slide_go;

    assign win = {bus.indata, prev_q};

    gtxe2_chnl_rx_align_lock_cmp #(
        .WIDTH  (WIDTH),
        .PVAL   (ALIGN_PCOMMA_VALUE),
        .MVAL   (ALIGN_MCOMMA_VALUE),
        .MASK   (ALIGN_COMMA_ENABLE),
        .PDET   (PDET),
        .MDET   (MDET),
        .DOUBLE (DOUBLE),
        .KW     (KW)
    ) u_cmp (
        .win_i  (win),
        .hits_o (cmp_hits),
        .hit_o  (cmp_hit),
        .k_o    (cmp_k),
        .kind_o (cmp_kind)
    );

    assign koff          = mod10(8'(cmp_k));
    assign comma_aligned = cmp_hit && (koff == off_q);
    assign realign_ok    = (cmp_kind == KIND_P) ? bus.RXPCOMMAALIGNEN : bus.RXMCOMMAALIGNEN;

`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
    logic       slide_q;
    logic [5:0] hold_q;

    assign slide_go = bus.RXSLIDE && !slide_q && (hold_q == 6'd0) &&
                      !bus.RXPCOMMAALIGNEN && !bus.RXMCOMMAALIGNEN && !bus.rxelecidle;

    // Slide edge detect and 32-clock hold-off after an accepted slide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slide_q <= 1'b0;
            hold_q  <= 6'd0;
        end else begin
            slide_q <= bus.RXSLIDE;
            if (slide_go)
                hold_q <= 6'd32;
            else if (hold_q != 6'd0)
                hold_q <= hold_q - 6'd1;
        end
    end
`else
    assign slide_go = 1'b0;
`endif

    // A comma is reported only if it lies fully inside the word being output.
    always_comb begin
        det_in_win = 1'b0;
        for (int k = 0; k < WIDTH; k++) begin
            if (cmp_hits[k] && (k >= int'(off_q)) && (k <= int'(off_q) + WIDTH - CW))
                det_in_win = 1'b1;
        end
        commadet_d = det_in_win && bus.RXCOMMADETEN;
    end

    // Next state: idle beats slide, slide beats comma handling.
    always_comb begin
        state_d = state_q;
        off_d   = off_q;
        loss_d  = loss_q;
        if (bus.rxelecidle) begin
            state_d = ST_UNALIGNED;
            loss_d  = 4'd0;
        end else if (slide_go) begin
            off_d   = off_next(off_q);
            state_d = ST_UNALIGNED;
            loss_d  = 4'd0;
        end else if (cmp_hit) begin
            if (comma_aligned) begin
                state_d = ST_ALIGNED;
                loss_d  = 4'd0;
            end else if (realign_ok) begin
                off_d   = koff;
                state_d = ST_ALIGNED;
                loss_d  = 4'd0;
            end else if (state_q == ST_ALIGNED) begin
                loss_d = sat_inc(loss_q);
                if (sat_inc(loss_q) >= LOSS_LIM) begin
                    state_d = ST_UNALIGNED;
                    loss_d  = 4'd0;
                end
            end
        end
        realign_d = (state_q == ST_ALIGNED) && (off_d != off_q);
    end

    // Control registers: state, boundary offset, loss counter, status pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_UNALIGNED;
            off_q      <= '0;
            loss_q     <= 4'd0;
            realign_q  <= 1'b0;
            commadet_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            off_q      <= off_d;
            loss_q     <= loss_d;
            realign_q  <= realign_d;
            commadet_q <= commadet_d;
        end
    end

    // Datapath: previous word and the shifted output word at the current offset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q    <= '0;
            outdata_q <= '0;
        end else begin
            prev_q    <= bus.indata;
            outdata_q <= win[off_q +: WIDTH];
        end
    end

    assign bus.outdata         = outdata_q;
    assign bus.RXBYTEISALIGNED = (state_q == ST_ALIGNED);
    assign bus.RXBYTEREALIGN   = realign_q;
    assign bus.RXCOMMADET      = commadet_q;
    assign bus.comma_off       = off_q;

endmodule

// File: tb/tb_gtxe2_chnl_rx_align_lock.sv
// Directed bench for the GTXE2 RX comma aligner: a WIDTH=20 single-comma
// instance and a WIDTH=40 double-comma instance side by side.
module tb_gtxe2_chnl_rx_align_lock;

    localparam logic [9:0]  PC   = 10'b0101111100;
    localparam logic [9:0]  MC   = 10'b1010000011;
    // P comma at word bits 3..12, M comma at word bits 7..16
    localparam logic [19:0] W_P3 = {7'd0, PC, 3'd0};
    localparam logic [19:0] W_M7 = {3'd0, MC, 7'd0};
    // 40-bit words: lone P at 12, and P then M at 12
    localparam logic [39:0] W_LP = {18'd0, PC, 12'd0};
    localparam logic [39:0] W_PM = {8'd0, MC, PC, 12'd0};

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;

    gtxe2_chnl_rx_align_lock_if #(.WIDTH(20)) ifa();
    gtxe2_chnl_rx_align_lock_if #(.WIDTH(40)) ifb();

    gtxe2_chnl_rx_align_lock #(.WIDTH(20), .LOSS_COUNT(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa.slave)
    );

    gtxe2_chnl_rx_align_lock #(.WIDTH(40), .ALIGN_COMMA_DOUBLE("TRUE"), .LOSS_COUNT(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ifa.indata = '0; ifa.rxelecidle = 1'b0; ifa.RXCOMMADETEN = 1'b0;
        ifa.RXPCOMMAALIGNEN = 1'b0; ifa.RXMCOMMAALIGNEN = 1'b0;
        ifb.indata = '0; ifb.rxelecidle = 1'b0; ifb.RXCOMMADETEN = 1'b0;
        ifb.RXPCOMMAALIGNEN = 1'b0; ifb.RXMCOMMAALIGNEN = 1'b0;
`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
        ifa.RXSLIDE = 1'b0;
        ifb.RXSLIDE = 1'b0;
`endif
        tick();
        tick();
        n_checks++; if (ifa.outdata !== 20'd0) begin n_fail++; $display("FAIL rst_outdata: got %0h want 0", ifa.outdata); end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL rst_isaligned: got %0b want 0", ifa.RXBYTEISALIGNED); end
        n_checks++; if (ifa.RXBYTEREALIGN !== 1'b0) begin n_fail++; $display("FAIL rst_realign: got %0b want 0", ifa.RXBYTEREALIGN); end
        n_checks++; if (ifa.RXCOMMADET !== 1'b0) begin n_fail++; $display("FAIL rst_commadet: got %0b want 0", ifa.RXCOMMADET); end
        n_checks++; if (ifa.comma_off !== 4'd0) begin n_fail++; $display("FAIL rst_off: got %0d want 0", ifa.comma_off); end
        n_checks++; if (ifb.outdata !== 40'd0) begin n_fail++; $display("FAIL rst_b_outdata: got %0h want 0", ifb.outdata); end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lock();
        ifa.RXPCOMMAALIGNEN = 1'b1;
        ifa.RXCOMMADETEN = 1'b1;
        ifa.indata = W_P3;
        tick();
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL lock_early: got %0b want 0", ifa.RXBYTEISALIGNED); end
        n_checks++; if (ifa.RXCOMMADET !== 1'b0) begin n_fail++; $display("FAIL lock_det_early: got %0b want 0", ifa.RXCOMMADET); end
        tick();
        n_checks++; if (ifa.comma_off !== 4'd3) begin n_fail++; $display("FAIL lock_off: got %0d want 3", ifa.comma_off); end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b1) begin n_fail++; $display("FAIL lock_isaligned: got %0b want 1", ifa.RXBYTEISALIGNED); end
        n_checks++; if (ifa.RXBYTEREALIGN !== 1'b0) begin n_fail++; $display("FAIL lock_realign: got %0b want 0", ifa.RXBYTEREALIGN); end
        tick();
        n_checks++; if (ifa.outdata[9:0] !== PC) begin n_fail++; $display("FAIL lock_outdata: got %b want %b", ifa.outdata[9:0], PC); end
        n_checks++; if (ifa.RXCOMMADET !== 1'b1) begin n_fail++; $display("FAIL lock_commadet: got %0b want 1", ifa.RXCOMMADET); end
    endtask

    task automatic test_realign();
        ifa.RXPCOMMAALIGNEN = 1'b0;
        ifa.RXMCOMMAALIGNEN = 1'b1;
        ifa.indata = W_M7;
        tick();
        tick();
        n_checks++; if (ifa.comma_off !== 4'd7) begin n_fail++; $display("FAIL realign_off: got %0d want 7", ifa.comma_off); end
        n_checks++; if (ifa.RXBYTEREALIGN !== 1'b1) begin n_fail++; $display("FAIL realign_pulse: got %0b want 1", ifa.RXBYTEREALIGN); end
        tick();
        n_checks++; if (ifa.RXBYTEREALIGN !== 1'b0) begin n_fail++; $display("FAIL realign_pulse_end: got %0b want 0", ifa.RXBYTEREALIGN); end
        ifa.RXMCOMMAALIGNEN = 1'b0;
        ifa.indata = W_P3;
        tick();
        ifa.indata = '0;
        tick();
        n_checks++; if (ifa.comma_off !== 4'd7) begin n_fail++; $display("FAIL noalign_off: got %0d want 7", ifa.comma_off); end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b1) begin n_fail++; $display("FAIL noalign_locked: got %0b want 1", ifa.RXBYTEISALIGNED); end
        n_checks++; if (ifa.RXBYTEREALIGN !== 1'b0) begin n_fail++; $display("FAIL noalign_realign: got %0b want 0", ifa.RXBYTEREALIGN); end
    endtask

    task automatic test_loss();
        logic [19:0] seq [9];
        seq = '{W_M7, W_P3, W_P3, W_P3, W_M7, W_P3, W_P3, W_P3, W_P3};
        for (int i = 0; i < 9; i++) begin
            ifa.indata = seq[i];
            tick();
        end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b1) begin n_fail++; $display("FAIL loss_three: got %0b want 1", ifa.RXBYTEISALIGNED); end
        ifa.indata = '0;
        tick();
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL loss_fourth: got %0b want 0", ifa.RXBYTEISALIGNED); end
        n_checks++; if (ifa.comma_off !== 4'd7) begin n_fail++; $display("FAIL loss_off: got %0d want 7", ifa.comma_off); end
    endtask

    task automatic test_double();
        ifb.RXPCOMMAALIGNEN = 1'b1;
        ifb.RXMCOMMAALIGNEN = 1'b1;
        ifb.RXCOMMADETEN = 1'b1;
        ifb.indata = W_LP;
        repeat (3) tick();
        n_checks++; if (ifb.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL dbl_lone_lock: got %0b want 0", ifb.RXBYTEISALIGNED); end
        n_checks++; if (ifb.comma_off !== 4'd0) begin n_fail++; $display("FAIL dbl_lone_off: got %0d want 0", ifb.comma_off); end
        n_checks++; if (ifb.RXCOMMADET !== 1'b0) begin n_fail++; $display("FAIL dbl_lone_det: got %0b want 0", ifb.RXCOMMADET); end
        ifb.indata = W_PM;
        tick();
        tick();
        n_checks++; if (ifb.comma_off !== 4'd2) begin n_fail++; $display("FAIL dbl_off: got %0d want 2", ifb.comma_off); end
        n_checks++; if (ifb.RXBYTEISALIGNED !== 1'b1) begin n_fail++; $display("FAIL dbl_lock: got %0b want 1", ifb.RXBYTEISALIGNED); end
        n_checks++; if (ifb.RXCOMMADET !== 1'b1) begin n_fail++; $display("FAIL dbl_det_on: got %0b want 1", ifb.RXCOMMADET); end
        ifb.RXCOMMADETEN = 1'b0;
        tick();
        n_checks++; if (ifb.RXCOMMADET !== 1'b0) begin n_fail++; $display("FAIL dbl_det_off: got %0b want 0", ifb.RXCOMMADET); end
        ifb.RXCOMMADETEN = 1'b1;
        tick();
        n_checks++; if (ifb.RXCOMMADET !== 1'b1) begin n_fail++; $display("FAIL dbl_det_again: got %0b want 1", ifb.RXCOMMADET); end
        n_checks++; if (ifb.comma_off !== 4'd2) begin n_fail++; $display("FAIL dbl_off_hold: got %0d want 2", ifb.comma_off); end
        ifb.indata = '0;
    endtask

    task automatic test_elecidle_reset();
        ifa.RXPCOMMAALIGNEN = 1'b0;
        ifa.RXMCOMMAALIGNEN = 1'b0;
        ifa.indata = W_M7;
        tick();
        tick();
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b1) begin n_fail++; $display("FAIL idle_relock: got %0b want 1", ifa.RXBYTEISALIGNED); end
        ifa.rxelecidle = 1'b1;
        tick();
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL idle_unlock: got %0b want 0", ifa.RXBYTEISALIGNED); end
        n_checks++; if (ifa.comma_off !== 4'd7) begin n_fail++; $display("FAIL idle_off: got %0d want 7", ifa.comma_off); end
        ifa.RXPCOMMAALIGNEN = 1'b1;
        ifa.indata = W_P3;
        tick();
        tick();
        n_checks++; if (ifa.comma_off !== 4'd7) begin n_fail++; $display("FAIL idle_off_held: got %0d want 7", ifa.comma_off); end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL idle_stay: got %0b want 0", ifa.RXBYTEISALIGNED); end
        ifa.rxelecidle = 1'b0;
        tick();
        n_checks++; if (ifa.comma_off !== 4'd3) begin n_fail++; $display("FAIL idle_release_off: got %0d want 3", ifa.comma_off); end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b1) begin n_fail++; $display("FAIL idle_release_lock: got %0b want 1", ifa.RXBYTEISALIGNED); end
        tick();
        n_checks++; if (ifa.outdata[9:0] !== PC) begin n_fail++; $display("FAIL pre_rst_outdata: got %b want %b", ifa.outdata[9:0], PC); end
        #2;
        rst = 1'b1;
        #1;
        n_checks++; if (ifa.outdata !== 20'd0) begin n_fail++; $display("FAIL mid_rst_outdata: got %0h want 0", ifa.outdata); end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL mid_rst_lock: got %0b want 0", ifa.RXBYTEISALIGNED); end
        n_checks++; if (ifa.comma_off !== 4'd0) begin n_fail++; $display("FAIL mid_rst_off: got %0d want 0", ifa.comma_off); end
        n_checks++; if (ifa.RXCOMMADET !== 1'b0) begin n_fail++; $display("FAIL mid_rst_det: got %0b want 0", ifa.RXCOMMADET); end
        n_checks++; if (ifb.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL mid_rst_b_lock: got %0b want 0", ifb.RXBYTEISALIGNED); end
        ifa.indata = '0;
        ifa.RXPCOMMAALIGNEN = 1'b0;
        rst = 1'b0;
        tick();
    endtask

`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
    task automatic test_slide();
        tick();
        ifa.RXSLIDE = 1'b1;
        tick();
        ifa.RXSLIDE = 1'b0;
        n_checks++; if (ifa.comma_off !== 4'd1) begin n_fail++; $display("FAIL slide_first: got %0d want 1", ifa.comma_off); end
        n_checks++; if (ifa.RXBYTEISALIGNED !== 1'b0) begin n_fail++; $display("FAIL slide_unlock: got %0b want 0", ifa.RXBYTEISALIGNED); end
        repeat (9) tick();
        ifa.RXSLIDE = 1'b1;
        tick();
        ifa.RXSLIDE = 1'b0;
        n_checks++; if (ifa.comma_off !== 4'd1) begin n_fail++; $display("FAIL slide_holdoff: got %0d want 1", ifa.comma_off); end
        repeat (29) tick();
        ifa.RXSLIDE = 1'b1;
        tick();
        ifa.RXSLIDE = 1'b0;
        n_checks++; if (ifa.comma_off !== 4'd2) begin n_fail++; $display("FAIL slide_second: got %0d want 2", ifa.comma_off); end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_lock();
        test_realign();
        test_loss();
        test_double();
        test_elecidle_reset();
`ifdef GTXE2_CHNL_RX_ALIGN_SLIDE_EN
        test_slide();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
